// File: rtl/pattern_scan_ctrl_if.sv
// Byte stream feeding the pattern scanner: valid/ready handshake plus an
// end-of-frame marker on the final byte.
interface pattern_scan_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Runtime-configurable serial pattern scanner: bytes are shifted MSB-first into
// a history register, compared against a programmable pattern, and counted per frame.
module pattern_scan_ctrl #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_we,
   input  logic [PAT_W-1:0]       cfg_pattern,
   input  logic [LEN_W-1:0]       cfg_len,
   input  logic                   cfg_overlap,
   pattern_scan_ctrl_if.slave     stream,
   output logic                   busy,
   output logic                   hit,
   output logic                   done,
   output logic [CNT_W-1:0]       result_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

   localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state, state_nxt;
   logic [7:0]         byte_q;
   logic               last_q;
   logic [2:0]         bit_idx;
   logic [PAT_W-1:0]   hist;
   logic [LEN_W-1:0]   fill;
   logic [CNT_W-1:0]   hit_cnt;
   logic [PAT_W-1:0]   pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic               hit_q;
   logic [CNT_W-1:0]   result_q;

   logic               take;
   logic               cfg_take;
   logic [LEN_W-1:0]   len_clamp;
   logic [PAT_W-1:0]   hist_nxt;
   logic [LEN_W-1:0]   fill_inc;
   logic [PAT_W-1:0]   len_mask;
   logic               match;
   logic [CNT_W-1:0]   cnt_nxt;

   // NOTE: in_ready depends only on registered state, so the handshake below
   // never feeds back into its own readiness and no combinational loop forms.
   assign stream.in_ready = (state == IDLE) ||
                            ((state == SHIFT) && (bit_idx == 3'd0) && !last_q);
   assign take      = stream.in_valid && stream.in_ready;
   assign cfg_take  = cfg_we && (state == IDLE);
   assign len_clamp = (cfg_len > PAT_LEN) ? PAT_LEN : cfg_len;

   assign hist_nxt  = {hist[PAT_W-2:0], byte_q[bit_idx]};
   assign fill_inc  = (fill == PAT_LEN) ? fill : fill + 1'b1;

   always_comb begin
      len_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end
   end

   assign match = (state == SHIFT) && (len_q != '0) && (fill_inc >= len_q) &&
                  (((hist_nxt ^ pat_q) & len_mask) == '0);

   always_comb begin
      cnt_nxt = hit_cnt;
      if (match && (hit_cnt != CNT_MAX)) begin
         cnt_nxt = hit_cnt + 1'b1;
      end
   end

   // NOTE: the reset branch sits inside the clocked block, making it
   // synchronous; sequential state is always assigned with <=.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (take) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if ((bit_idx == 3'd0) && !take) begin
               state_nxt = last_q ? REPORT : IDLE;
            end
         end
         REPORT: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_q   <= '0;
         last_q   <= 1'b0;
         bit_idx  <= '0;
         hist     <= '0;
         fill     <= '0;
         hit_cnt  <= '0;
         pat_q    <= '0;
         len_q    <= '0;
         ovl_q    <= 1'b0;
         hit_q    <= 1'b0;
         result_q <= '0;
      end else begin
         hit_q <= match;

         if (cfg_take) begin
            pat_q <= cfg_pattern;
            len_q <= len_clamp;
            ovl_q <= cfg_overlap;
         end

         if (take) begin
            byte_q  <= stream.in_data;
            last_q  <= stream.in_last;
            bit_idx <= 3'd7;
         end else if (state == SHIFT) begin
            bit_idx <= bit_idx - 1'b1;
         end

         if (state == SHIFT) begin
            hist    <= hist_nxt;
            fill    <= (match && !ovl_q) ? '0 : fill_inc;
            hit_cnt <= cnt_nxt;
            // Final bit of the frame: publish the count including this bit's match.
            if ((bit_idx == 3'd0) && last_q) begin
               result_q <= cnt_nxt;
            end
         end else if (state == REPORT) begin
            hist    <= '0;
            fill    <= '0;
            hit_cnt <= '0;
         end
      end
   end

   assign hit        = hit_q;
   assign result_cnt = result_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: two instances (8-bit and 2-bit counters)
// see identical stimulus; hit positions are logged relative to the first handshake.
module tb_pattern_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;

   logic       busy1, hit1, done1;
   logic [7:0] res1;
   logic       busy2, hit2, done2;
   logic [1:0] res2;

   pattern_scan_ctrl_if s1 ();
   pattern_scan_ctrl_if s2 ();

   assign s2.in_valid = s1.in_valid;
   assign s2.in_data  = s1.in_data;
   assign s2.in_last  = s1.in_last;

   pattern_scan_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .stream(s1),
      .busy(busy1), .hit(hit1), .done(done1), .result_cnt(res1)
   );

   pattern_scan_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .stream(s2),
      .busy(busy2), .hit(hit2), .done(done2), .result_cnt(res2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int         n_vec = 0;
   int         n_err = 0;
   int         hit_cyc[$];
   int         done_cyc[$];
   logic [7:0] done_res;
   int         hit_n2;
   logic [1:0] done_res2;
   int         c0;
   int         hs_cyc[4];

   always @(negedge clk) begin
      if (hit1)  hit_cyc.push_back(cyc);
      if (done1) begin done_cyc.push_back(cyc); done_res = res1; end
      if (hit2)  hit_n2++;
      if (done2) done_res2 = res2;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      cfg_we      = 1'b1;
      @(negedge clk);
      cfg_we      = 1'b0;
   endtask

   task automatic clear_mon();
      hit_cyc.delete();
      done_cyc.delete();
      done_res  = '0;
      hit_n2    = 0;
      done_res2 = '0;
   endtask

   // Returns at the negedge after the last byte's handshake edge.
   task automatic send_frame(input logic [31:0] bytes, input int n);
      int budget;
      for (int i = 0; i < n; i++) begin
         budget      = 0;
         s1.in_valid = 1'b1;
         s1.in_data  = bytes[8*(n-1-i) +: 8];
         s1.in_last  = (i == n - 1);
         while (!s1.in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
         end
         check("handshake_timeout", 32'(budget >= 20), 32'd0);
         @(negedge clk);
         hs_cyc[i] = cyc;
         if (i == 0) c0 = cyc;
      end
      s1.in_valid = 1'b0;
      s1.in_last  = 1'b0;
   endtask

   task automatic wait_done();
      int budget;
      budget = 0;
      while (done_cyc.size() == 0 && budget < 40) begin
         @(negedge clk);
         budget++;
      end
      check("done_timeout", 32'(budget >= 40), 32'd0);
      @(negedge clk);
   endtask

   function automatic logic [31:0] hit_mask();
      logic [31:0] m;
      int          k;
      m = '0;
      foreach (hit_cyc[i]) begin
         k = hit_cyc[i] - c0;
         if (k >= 1 && k <= 32) m[k-1] = 1'b1;
      end
      return m;
   endfunction

   function automatic int done_at();
      return (done_cyc.size() == 0) ? -1 : done_cyc[0] - c0;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      s1.in_valid = 1'b0;
      s1.in_data  = '0;
      s1.in_last  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      check("rst_ready",  32'(s1.in_ready), 32'd1);
      check("rst_busy",   32'(busy1),       32'd0);
      check("rst_hit",    32'(hit1),        32'd0);
      check("rst_done",   32'(done1),       32'd0);
      check("rst_result", 32'(res1),        32'd0);

      // Overlapping 1010 over 0xAA: matches after bits 4, 6, 8.
      configure(8'h0A, 4'd4, 1'b1);
      clear_mon();
      send_frame(32'hAA, 1);
      check("ovl_busy", 32'(busy1), 32'd1);
      wait_done();
      check("ovl_hits",    hit_mask(),        32'hA8);
      check("ovl_done_at", 32'(done_at()),    32'd8);
      check("ovl_result",  32'(done_res),     32'd3);
      check("ovl_hold",    32'(res1),         32'd3);
      check("ovl_pulses",  32'(done_cyc.size()), 32'd1);
      check("ovl_idle",    32'(busy1),        32'd0);

      // Non-overlapping: matches after bits 4 and 8.
      configure(8'h0A, 4'd4, 1'b0);
      clear_mon();
      send_frame(32'hAA, 1);
      wait_done();
      check("novl_hits",   hit_mask(),    32'h88);
      check("novl_result", 32'(done_res), 32'd2);

      // Back-to-back bytes with a match spanning the byte boundary.
      configure(8'h0A, 4'd4, 1'b1);
      clear_mon();
      send_frame(32'h050A, 2);
      wait_done();
      check("b2b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd8);
      check("b2b_hits",    hit_mask(),     32'h8100);
      check("b2b_done_at", 32'(done_at()), 32'd16);
      check("b2b_result",  32'(done_res),  32'd2);

      // New frames start with empty history.
      clear_mon();
      send_frame(32'h0A, 1);
      wait_done();
      check("fresh0a_hits",   hit_mask(),    32'h80);
      check("fresh0a_result", 32'(done_res), 32'd1);
      clear_mon();
      send_frame(32'hA0, 1);
      wait_done();
      check("freshA0_hits",   hit_mask(),    32'h08);
      check("freshA0_result", 32'(done_res), 32'd1);

      // Length 0 disables matching.
      configure(8'hFF, 4'd0, 1'b1);
      clear_mon();
      send_frame(32'hFF, 1);
      wait_done();
      check("dis_hits",   32'(hit_cyc.size()), 32'd0);
      check("dis_result", 32'(done_res),       32'd0);

      // Length 15 clamps to 8.
      configure(8'hA5, 4'd15, 1'b1);
      clear_mon();
      send_frame(32'hA5, 1);
      wait_done();
      check("clamp_hits",   hit_mask(),    32'h80);
      check("clamp_result", 32'(done_res), 32'd1);

      // Config write during SHIFT is ignored, both for this frame and the next.
      configure(8'h0A, 4'd4, 1'b1);
      clear_mon();
      send_frame(32'hAA, 1);
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cfg_we      = 1'b1;
      @(negedge clk);
      cfg_we      = 1'b0;
      wait_done();
      check("guard_result", 32'(done_res), 32'd3);
      clear_mon();
      send_frame(32'hAA, 1);
      wait_done();
      check("guard_next_result", 32'(done_res), 32'd3);

      // Saturation on the 2-bit counter instance; 8-bit instance counts all.
      configure(8'h01, 4'd1, 1'b1);
      clear_mon();
      send_frame(32'hFF, 1);
      wait_done();
      check("sat_hits8",    hit_mask(),     32'hFF);
      check("sat_result8",  32'(done_res),  32'd8);
      check("sat_hits2",    32'(hit_n2),    32'd8);
      check("sat_result2",  32'(done_res2), 32'd3);

      // Reset mid-SHIFT discards the frame.
      configure(8'h0A, 4'd4, 1'b1);
      clear_mon();
      send_frame(32'hAA, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_ready",  32'(s1.in_ready), 32'd1);
      check("mid_rst_busy",   32'(busy1),       32'd0);
      check("mid_rst_hit",    32'(hit1),        32'd0);
      check("mid_rst_done",   32'(done1),       32'd0);
      check("mid_rst_result", 32'(res1),        32'd0);
      repeat (12) @(negedge clk);
      check("mid_rst_no_done", 32'(done_cyc.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
